// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
//   Top-level game sequencer wrapped around player_physics. Decides when the
//   physics runs (freeze), restarts the player at the spawn point
//   (player_rst_n), counts lives and landings, and detects death, win and
//   game over. Every register advances only on game_tick, except
//   player_rst_n, which returns high on the clk after it drops.
//
//   Optional feature macro: TIME_LIMIT_EN
//     defined   -> per-level countdown in time_left; reaching 0 kills the player
//     undefined -> time_left is tied to 0 and no counter is built
//
// Ports:
//   clk               in   system clock
//   rst               in   asynchronous, active-low reset
//   game_tick         in   one-clk pulse per frame, qualifies all updates
//   start_btn         in   start button level (already synchronised)
//   player_y [9:0]    in   player top y from player_physics
//   hazard_hit        in   player overlaps a hazard this frame
//   goal_reached      in   player overlaps the goal flag this frame
//   jump_landed_pulse in   landing pulse from player_physics
//   freeze            out  stalls player_physics (1 except in PLAY)
//   player_rst_n      out  active-low one-clk restart for player_physics
//   state [2:0]       out  0 ATTRACT,1 PLAY,2 DYING,3 RESPAWN,4 WIN,5 GAME_OVER
//   lives [1:0]       out  remaining lives
//   score [7:0]       out  landings this game, saturating at 255
//   time_left [11:0]  out  ticks left in the level (0 without TIME_LIMIT_EN)
// -----------------------------------------------------------------------------
module game_flow_ctrl #(
    parameter int LIVES_INIT  = 3,
    parameter int DIE_TICKS   = 30,
    parameter int FALL_Y      = 470,
    parameter int LEVEL_TICKS = 3600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_tick,
    input  logic        start_btn,
    input  logic [9:0]  player_y,
    input  logic        hazard_hit,
    input  logic        goal_reached,
    input  logic        jump_landed_pulse,
    output logic        freeze,
    output logic        player_rst_n,
    output logic [2:0]  state,
    output logic [1:0]  lives,
    output logic [7:0]  score,
    output logic [11:0] time_left
);

    localparam logic [2:0] S_ATTRACT   = 3'd0;
    localparam logic [2:0] S_PLAY      = 3'd1;
    localparam logic [2:0] S_DYING     = 3'd2;
    localparam logic [2:0] S_RESPAWN   = 3'd3;
    localparam logic [2:0] S_WIN       = 3'd4;
    localparam logic [2:0] S_GAME_OVER = 3'd5;

    localparam int DW = (DIE_TICKS > 1) ? $clog2(DIE_TICKS) : 1;
    localparam logic [DW-1:0] DIE_LAST = DW'(DIE_TICKS - 1);

    logic [DW-1:0] die_cnt, die_nxt;
    logic          start_prev;
    logic [2:0]    state_nxt;
    logic [1:0]    lives_nxt;
    logic [7:0]    score_nxt;
    logic          tl_reload;
    logic          start_edge;
    logic          time_out;
    logic          died;

    assign start_edge = start_btn & ~start_prev;
    assign freeze     = (state != S_PLAY);

`ifdef TIME_LIMIT_EN
    // Checked against the registered value, so the death lands on the tick
    // after the counter has reached 0.
    assign time_out = (time_left == 12'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_left <= 12'd0;
        end else if (game_tick) begin
            if (tl_reload)
                time_left <= 12'(LEVEL_TICKS);
            else if (state == S_PLAY && time_left != 12'd0)
                time_left <= time_left - 12'd1;
        end
    end
`else
    logic unused_tl_reload;
    assign unused_tl_reload = tl_reload;
    assign time_out         = 1'b0;
    assign time_left        = 12'd0;
`endif

    assign died = hazard_hit | (player_y >= 10'(FALL_Y)) | time_out;

    always_comb begin
        state_nxt = state;
        lives_nxt = lives;
        score_nxt = score;
        die_nxt   = die_cnt;
        tl_reload = 1'b0;
        case (state)
            S_ATTRACT: begin
                if (start_edge) begin
                    lives_nxt = 2'(LIVES_INIT);
                    score_nxt = 8'd0;
                    tl_reload = 1'b1;
                    state_nxt = S_RESPAWN;
                end
            end
            S_RESPAWN: state_nxt = S_PLAY;
            S_PLAY: begin
                // A landing still counts on the tick that ends the play.
                if (jump_landed_pulse && score != 8'hFF)
                    score_nxt = score + 8'd1;
                if (died) begin
                    state_nxt = S_DYING;
                    die_nxt   = '0;
                end else if (goal_reached) begin
                    state_nxt = S_WIN;
                end
            end
            S_DYING: begin
                if (die_cnt == DIE_LAST) begin
                    die_nxt = '0;
                    if (lives <= 2'd1) begin
                        lives_nxt = 2'd0;
                        state_nxt = S_GAME_OVER;
                    end else begin
                        lives_nxt = lives - 2'd1;
                        tl_reload = 1'b1;
                        state_nxt = S_RESPAWN;
                    end
                end else begin
                    die_nxt = die_cnt + 1'b1;
                end
            end
            S_WIN, S_GAME_OVER: begin
                if (start_edge)
                    state_nxt = S_ATTRACT;
            end
            default: state_nxt = S_ATTRACT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_ATTRACT;
            lives        <= 2'd0;
            score        <= 8'd0;
            die_cnt      <= '0;
            start_prev   <= 1'b0;
            player_rst_n <= 1'b1;
        end else begin
            // Low for the single clk following the tick that enters RESPAWN.
            player_rst_n <= 1'b1;
            if (game_tick) begin
                state        <= state_nxt;
                lives        <= lives_nxt;
                score        <= score_nxt;
                die_cnt      <= die_nxt;
                start_prev   <= start_btn;
                player_rst_n <= ~(state_nxt == S_RESPAWN && state != S_RESPAWN);
            end
        end
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer that owns player_physics. It decides when physics runs (freeze), restarts the player at the spawn point (player_rst_n), counts lives and landings, and detects death, win and game over. It sits between the VGA/tick generator and player_physics, and its state drives HUD/overlay rendering.

Parameters:
LIVES_INIT, 3, lives loaded on game start (1..3; fits lives[1:0])
DIE_TICKS, 30, game ticks spent in DYING before respawn/game-over decision
FALL_Y, 470, player_y at or above this value counts as fallen off screen
LEVEL_TICKS, 3600, level time budget in game ticks (used only with TIME_LIMIT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
game_tick  in  1  one-clk pulse per frame; all state updates qualify on it
start_btn  in  1  raw start button level, already synchronised
player_y  in  10  player top y from player_physics
hazard_hit  in  1  player overlaps a hazard this frame
goal_reached  in  1  player overlaps the goal flag this frame
jump_landed_pulse  in  1  landing pulse from player_physics
freeze  out  1  to player_physics; 1 in every state except PLAY
player_rst_n  out  1  active-low restart to player_physics; low for exactly one clk
state  out  3  0 ATTRACT, 1 PLAY, 2 DYING, 3 RESPAWN, 4 WIN, 5 GAME_OVER
lives  out  2  remaining lives
score  out  8  landings this game, saturating at 255
time_left  out  12  ticks remaining in the level; constant 0 without TIME_LIMIT_EN

Behaviour:
- Reset: state=ATTRACT, freeze=1, player_rst_n=1, lives=0, score=0, time_left=0, die_cnt=0, start_prev=0.
- start_btn is sampled only on game_tick. start_edge = start_btn & ~start_prev. start_prev updates every game_tick.
- Registers change only on game_tick, with one exception: player_rst_n returns to 1 on the clk after it goes low.
- ATTRACT: on start_edge, set lives=LIVES_INIT, score=0, time_left=LEVEL_TICKS, then go to RESPAWN.
- RESPAWN: on entry, drive player_rst_n low for one clk, registered on the clk after the entering tick. On the next game_tick go to PLAY. freeze=1 throughout.
- PLAY, checked in priority order on each tick:
  1. Death: hazard_hit, or player_y >= FALL_Y, or (TIME_LIMIT_EN and time_left==0). Go to DYING, die_cnt=0.
  2. goal_reached: go to WIN.
  3. Otherwise stay in PLAY.
- PLAY, score: jump_landed_pulse increments score (saturates at 255). The increment applies even on the tick death or win is taken.
- DYING: die_cnt increments each tick. When die_cnt==DIE_TICKS-1:
  - if lives<=1, set lives=0 and go to GAME_OVER;
  - else decrement lives, reload time_left=LEVEL_TICKS, and go to RESPAWN.
  - Score is kept across deaths.
- WIN and GAME_OVER: hold score and lives. On start_edge go to ATTRACT. A held button never re-triggers, because the edge detector requires a release first.
- Death and goal on the same tick: death wins.
- start_btn in PLAY, DYING or RESPAWN: ignored, but start_prev still updates.
- Reset mid-game: async return to ATTRACT. player_rst_n is 1 during reset; player_physics has its own rst.
- Widths: die_cnt is sized by $clog2(DIE_TICKS). The lives decrement never underflows.

Optional Feature:
TIME_LIMIT_EN
- Defined: in PLAY, time_left decrements by 1 per tick and saturates at 0. Reaching 0 is a death condition, checked on the tick after the counter reaches 0. time_left reloads on game start and on every respawn.
- Undefined: time_left is constant 0, the timer is not a death cause, and no counter logic is synthesised.

Test Plan:
- Power-on: rst low then high → state=0, freeze=1, lives=0, score=0, player_rst_n=1. start_btn held high from reset → one start_edge, then RESPAWN, a single one-clk player_rst_n low, then PLAY at the next tick with lives=3.
- In PLAY, 5 jump_landed_pulse ticks → score=5. Force score to 255 plus one more pulse → stays 255.
- hazard_hit for 1 tick with lives=3 → DYING, freeze=1. After exactly 30 ticks → RESPAWN with lives=2, then PLAY. Repeat until lives=1, then die → GAME_OVER with lives=0, and score is kept.
- player_y=470 → death. player_y=469 → stays in PLAY. hazard_hit and goal_reached on the same tick → DYING, not WIN.
- goal_reached → WIN. Hold start_btn with no release → stays in WIN. Release then press → ATTRACT. Press again → new game with score=0 and lives=3.
- TIME_LIMIT_EN with LEVEL_TICKS=10: after 10 PLAY ticks time_left=0, and the next tick → DYING. After respawn time_left=10. Without the macro, time_left stays 0 for 1000 PLAY ticks with no death.
